// File: rtl/rr_grant_arbiter_4.sv
// Four-way round-robin grant arbiter with a hold limit: a contended holder is
// pre-empted after MAX_HOLD cycles, and every grant ends with one idle cycle.
module rr_grant_arbiter_4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       busy,
    output logic       dbg_state,
    output logic [1:0] dbg_ptr,
    output logic [7:0] dbg_hcnt
);

    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state, state_n;
    logic [1:0] ptr, ptr_n;
    logic [7:0] hcnt, hcnt_n;
    logic [1:0] idx_n;
    logic [3:0] gnt_n;
    logic       busy_n;
    logic [1:0] sel_idx;
    logic       others;

    // Scan from the farthest candidate back to ptr so the nearest set bit wins.
    always_comb begin
        sel_idx = ptr;
        for (int k = 3; k >= 0; k--) begin
            if (req[ptr + 2'(k)]) begin
                sel_idx = ptr + 2'(k);
            end
        end
    end

    assign others = |(req & ~(4'b0001 << gnt_idx));

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        hcnt_n  = hcnt;
        idx_n   = gnt_idx;
        gnt_n   = gnt;
        busy_n  = busy;
        case (state)
            IDLE: begin
                if (en && (|req)) begin
                    state_n = GRANT;
                    idx_n   = sel_idx;
                    gnt_n   = 4'b0001 << sel_idx;
                    busy_n  = 1'b1;
                    hcnt_n  = 8'd1;
                end
            end
            GRANT: begin
                // Release and pre-emption lead to the same exit, so release
                // priority holds without a separate branch.
                if (!en || !req[gnt_idx] || ((hcnt == HOLD_MAX) && others)) begin
                    state_n = IDLE;
                    gnt_n   = 4'b0000;
                    busy_n  = 1'b0;
                    ptr_n   = gnt_idx + 2'd1;
                end else if (hcnt < HOLD_MAX) begin
                    hcnt_n = hcnt + 8'd1;
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = 4'b0000;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= 2'd0;
            hcnt    <= 8'd0;
            gnt_idx <= 2'd0;
            gnt     <= 4'b0000;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            hcnt    <= hcnt_n;
            gnt_idx <= idx_n;
            gnt     <= gnt_n;
            busy    <= busy_n;
        end
    end

    assign dbg_state = state;
    assign dbg_ptr   = ptr;
    assign dbg_hcnt  = hcnt;

endmodule

// File: doc/rr_grant_arbiter_4.md
RR_GRANT_ARBITER_4 -- requirements
Module: rr_grant_arbiter_4

Interface
REQ-001 Parameter MAX_HOLD, default 8, sets the maximum consecutive grant cycles before a contended grant is pre-empted; legal range 1..255.
REQ-002 Port CLK  input  1  single clock; all state updates occur on its rising edge.
REQ-003 Port RST  input  1  reset, asynchronous, active-high.
REQ-004 Port EN  input  1  global arbitration enable, active-high.
REQ-005 Port REQ  input  4  request vector; bit i is requester i.
REQ-006 Port GNT  output  4  registered one-hot grant (2-to-4 decode of GNT_IDX, gated by BUSY); all zeros when no grant is active.
REQ-007 Port GNT_IDX  output  2  registered index of the current or last granted requester.
REQ-008 Port BUSY  output  1  registered; high exactly when GNT is non-zero.

Function
REQ-009 The block SHALL implement two states, IDLE and GRANT, plus a 2-bit round-robin pointer PTR and an 8-bit hold counter HCNT.
REQ-010 In IDLE, GNT SHALL be 4'b0000 and BUSY SHALL be 0.
REQ-011 IDLE with EN=1 and REQ!=0 at a rising edge: the block SHALL select the first set REQ bit, searching PTR, PTR+1, PTR+2, PTR+3 (mod 4).
REQ-012 On that edge it SHALL load GNT_IDX with the selected index, assert GNT/BUSY, set HCNT=1 and enter GRANT, giving 1-cycle latency from REQ sample to GNT.
REQ-013 IDLE with EN=0 or REQ=0 SHALL hold all state unchanged.
REQ-014 GRANT, release: if REQ[GNT_IDX]=0 or EN=0 at an edge, the block SHALL deassert GNT/BUSY on that edge, set PTR=GNT_IDX+1 (mod 4) and enter IDLE.
REQ-015 GRANT, pre-empt: if HCNT=MAX_HOLD and any other REQ bit is set at an edge, the block SHALL deassert GNT/BUSY, set PTR=GNT_IDX+1 (mod 4) and enter IDLE.
REQ-016 GRANT otherwise SHALL keep GNT unchanged and increment HCNT, saturating at MAX_HOLD; an uncontended holder is never pre-empted.
REQ-017 Release (REQ-014) SHALL take priority over pre-emption (REQ-015) when both apply on the same edge.
REQ-018 Every grant SHALL be followed by at least one IDLE cycle with GNT=0000, so two requesters are never granted back-to-back without a gap.
REQ-019 GNT SHALL never have more than one bit set; GNT_IDX SHALL hold its value in IDLE.
REQ-020 Changes on REQ bits other than GNT_IDX during GRANT SHALL NOT affect GNT, except through REQ-015.
REQ-021 PTR SHALL wrap from 3 to 0.

Reset
REQ-022 RST=1 SHALL immediately, without waiting for a clock edge, force state=IDLE, GNT=0000, GNT_IDX=00, BUSY=0, PTR=00 and HCNT=0.
REQ-023 While RST=1, REQ and EN SHALL be ignored; arbitration SHALL resume on the first rising edge after RST falls.
REQ-024 Assertion of RST mid-grant SHALL abort the grant with no residual state.

Verification (MAX_HOLD=4)
REQ-025 Reset: RST=1, EN=1, REQ=1111 for 3 edges -> GNT=0000, GNT_IDX=00, BUSY=0 throughout.
REQ-026 Enable gating: EN=0, REQ=0101 for 5 edges -> GNT stays 0000; raise EN=1 -> GNT=0001 after the next edge.
REQ-027 Single request: REQ=0001 from reset -> GNT=0001, GNT_IDX=00, BUSY=1 one edge later; drop REQ -> GNT=0000 on the next edge, PTR=01.
REQ-028 Round-robin/pre-empt: REQ=1111 held constant -> GNT sequence: 0001 x4, 0000 x1, 0010 x4, 0000 x1, 0100 x4, 0000 x1, 1000 x4, 0000 x1, 0001.
REQ-029 Saturation: only REQ=0100 held 10 cycles -> GNT=0100 continuously, no gap; then raise REQ[0] -> GNT=0000 on the next edge, then 0001.
REQ-030 Async reset mid-grant: RST pulsed between edges while GNT=0010 -> GNT=0000 before the next edge; after RST falls with REQ=0110 -> GNT=0010 (search from PTR=0).
